// File: rtl/id_ex_hazard_pipe_if.sv
// Bus between the IF/ID register, the decode/ID-EX block and the execute stage.
// IDEX_PERF_CNT_EN adds the bubble_cnt_o observation signal.
interface id_ex_hazard_pipe_if #(
  parameter int unsigned I = 16,
  parameter int unsigned P = 16,
  parameter int unsigned D = 16,
  parameter int unsigned R = 4,
  parameter int unsigned F = 4
);
  logic         valid_i;
  logic [P-1:0] next_pc_i;
  logic [I-1:0] instr_i;
  logic         stall_i;
  logic         flush_i;
  logic         we3_i;
  logic [R-1:0] wa3_i;
  logic [D-1:0] wd3_i;
  logic         stall_o;
  logic         valid_o;
  logic [P-1:0] next_pc_o;
  logic [F-1:0] funct4_o;
  logic [R-1:0] rd_o;
  logic [D-1:0] rs_o;
  logic [D-1:0] rt_o;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0]  bubble_cnt_o;
`endif

  modport slave (
    input  valid_i, next_pc_i, instr_i, stall_i, flush_i, we3_i, wa3_i, wd3_i,
`ifdef IDEX_PERF_CNT_EN
    output bubble_cnt_o,
`endif
    output stall_o, valid_o, next_pc_o, funct4_o, rd_o, rs_o, rt_o
  );

  modport master (
    output valid_i, next_pc_i, instr_i, stall_i, flush_i, we3_i, wa3_i, wd3_i,
`ifdef IDEX_PERF_CNT_EN
    input  bubble_cnt_o,
`endif
    input  stall_o, valid_o, next_pc_o, funct4_o, rd_o, rs_o, rt_o
  );
endinterface

// File: rtl/id_ex_hazard_pipe.sv
// Decode + register file with write-through bypass + load-use hazard + ID/EX register.
// Optional macro IDEX_PERF_CNT_EN adds a saturating bubble counter (bubble_cnt_o).
module id_ex_hazard_pipe #(
  parameter int unsigned I       = 16,
  parameter int unsigned P       = 16,
  parameter int unsigned D       = 16,
  parameter int unsigned R       = 4,
  parameter int unsigned F       = 4,
  parameter logic [F-1:0] LOAD_OP = F'(4'hB)
) (
  input  logic clk_i,
  input  logic rst_i,
  id_ex_hazard_pipe_if.slave bus
);
  localparam int unsigned NREG = 1 << R;

  logic [D-1:0] regs [NREG];

  logic [F-1:0] funct;
  logic [R-1:0] rd_addr;
  logic [R-1:0] rs_addr;
  logic [R-1:0] rt_addr;
  logic [D-1:0] rs_val;
  logic [D-1:0] rt_val;
  logic         hazard;

  logic         valid_q;
  logic [P-1:0] next_pc_q;
  logic [F-1:0] funct_q;
  logic [R-1:0] rd_q;
  logic [D-1:0] rs_q;
  logic [D-1:0] rt_q;

  assign funct   = bus.instr_i[I-1 -: F];
  assign rd_addr = bus.instr_i[I-F-1 -: R];
  assign rs_addr = bus.instr_i[I-F-R-1 -: R];
  assign rt_addr = bus.instr_i[I-F-2*R-1 -: R];

  // Register file; r0 is never written so it stays zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(NREG); k++) regs[k] <= '0;
    end else if (bus.we3_i && bus.wa3_i != '0) begin
      regs[bus.wa3_i] <= bus.wd3_i;
    end
  end

  // Write-through bypass so writeback in this cycle is seen by decode.
  always_comb begin
    rs_val = regs[rs_addr];
    rt_val = regs[rt_addr];
    if (bus.we3_i && bus.wa3_i == rs_addr) rs_val = bus.wd3_i;
    if (bus.we3_i && bus.wa3_i == rt_addr) rt_val = bus.wd3_i;
    if (rs_addr == '0) rs_val = '0;
    if (rt_addr == '0) rt_val = '0;
  end

  assign hazard = bus.valid_i && valid_q && (funct_q == LOAD_OP) && (rd_q != '0) &&
                  ((rd_q == rs_addr) || (rd_q == rt_addr));

  // Not gated by flush: fetch resolves flush priority itself.
  assign bus.stall_o = hazard | bus.stall_i;

  // ID/EX register: flush > stall hold > hazard bubble > load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      next_pc_q <= '0;
      funct_q   <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
    end else if (bus.flush_i || (!bus.stall_i && hazard)) begin
      valid_q   <= 1'b0;
      next_pc_q <= '0;
      funct_q   <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
    end else if (!bus.stall_i) begin
      valid_q   <= bus.valid_i;
      next_pc_q <= bus.next_pc_i;
      funct_q   <= funct;
      rd_q      <= rd_addr;
      rs_q      <= rs_val;
      rt_q      <= rt_val;
    end
  end

  assign bus.valid_o   = valid_q;
  assign bus.next_pc_o = next_pc_q;
  assign bus.funct4_o  = funct_q;
  assign bus.rd_o      = rd_q;
  assign bus.rs_o      = rs_q;
  assign bus.rt_o      = rt_q;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q;

  // Counts loaded bubbles only; stall hold cycles do not count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt_q <= '0;
    end else if ((bus.flush_i || (!bus.stall_i && hazard)) && bubble_cnt_q != '1) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bus.bubble_cnt_o = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_hazard_pipe.sv
// Directed self-checking bench for id_ex_hazard_pipe (default and IDEX_PERF_CNT_EN builds).
module tb_id_ex_hazard_pipe;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   exp_bub = 0;
  logic [56:0] exp_out;

  always #5 clk = ~clk;

  id_ex_hazard_pipe_if bus ();

  id_ex_hazard_pipe dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [56:0] outs();
    return {bus.valid_o, bus.next_pc_o, bus.funct4_o, bus.rd_o, bus.rs_o, bus.rt_o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid_i   = 1'b0;
    bus.next_pc_i = '0;
    bus.instr_i   = '0;
    bus.stall_i   = 1'b0;
    bus.flush_i   = 1'b0;
    bus.we3_i     = 1'b0;
    bus.wa3_i     = '0;
    bus.wd3_i     = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    bus.valid_i = 1'b0;
    bus.we3_i   = 1'b1;
    bus.wa3_i   = a;
    bus.wd3_i   = d;
    step();
    bus.we3_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    total++;
    if (outs() !== 57'd0) begin
      bad++;
      $display("FAIL reset_hold: got=%h want=0", outs());
    end
`ifdef IDEX_PERF_CNT_EN
    total++;
    if (bus.bubble_cnt_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_cnt: got=%0d want=0", bus.bubble_cnt_o);
    end
`endif
    rst = 1'b0;
    wr(4'd1, 16'h1234);
    bus.valid_i = 1'b1; bus.instr_i = 16'h3412; bus.next_pc_i = 16'd7;
    step();
    exp_out = {1'b1, 16'd7, 4'h3, 4'h4, 16'h1234, 16'h0000};
    total++;
    if (outs() !== exp_out) begin
      bad++;
      $display("FAIL pre_reset_load: got=%h want=%h", outs(), exp_out);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (outs() !== 57'd0) begin
      bad++;
      $display("FAIL async_reset: got=%h want=0", outs());
    end
    step();
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      bus.valid_i = 1'b1;
      bus.instr_i = {8'h00, 4'(a), 4'(a)};
      step();
      total++;
      if ({bus.rs_o, bus.rt_o} !== 32'd0) begin
        bad++;
        $display("FAIL rf_cleared r%0d: got=%h want=0", a, {bus.rs_o, bus.rt_o});
      end
    end
  endtask

  task automatic test_decode();
    wr(4'd9, 16'h00AA);
    wr(4'd10, 16'h0055);
    bus.valid_i = 1'b1; bus.instr_i = 16'h2A9A; bus.next_pc_i = 16'd42;
    step();
    exp_out = {1'b1, 16'd42, 4'h2, 4'hA, 16'h00AA, 16'h0055};
    total++;
    if (outs() !== exp_out) begin
      bad++;
      $display("FAIL decode: got=%h want=%h", outs(), exp_out);
    end
  endtask

  task automatic test_bypass();
    bus.we3_i = 1'b1; bus.wa3_i = 4'd3; bus.wd3_i = 16'hBEEF;
    bus.valid_i = 1'b1; bus.instr_i = 16'h1430; bus.next_pc_i = 16'd43;
    step();
    exp_out = {1'b1, 16'd43, 4'h1, 4'h4, 16'hBEEF, 16'h0000};
    total++;
    if (outs() !== exp_out) begin
      bad++;
      $display("FAIL bypass: got=%h want=%h", outs(), exp_out);
    end
    bus.we3_i = 1'b0; bus.instr_i = 16'h1033; bus.next_pc_i = 16'd44;
    step();
    exp_out = {1'b1, 16'd44, 4'h1, 4'h0, 16'hBEEF, 16'hBEEF};
    total++;
    if (outs() !== exp_out) begin
      bad++;
      $display("FAIL stored_r3: got=%h want=%h", outs(), exp_out);
    end
    bus.we3_i = 1'b1; bus.wa3_i = 4'd0; bus.wd3_i = 16'hFFFF;
    bus.instr_i = 16'h1000; bus.next_pc_i = 16'd45;
    step();
    exp_out = {1'b1, 16'd45, 4'h1, 4'h0, 16'h0000, 16'h0000};
    total++;
    if (outs() !== exp_out) begin
      bad++;
      $display("FAIL r0_no_bypass: got=%h want=%h", outs(), exp_out);
    end
    bus.we3_i = 1'b0;
    step();
    total++;
    if (outs() !== exp_out) begin
      bad++;
      $display("FAIL r0_stored: got=%h want=%h", outs(), exp_out);
    end
  endtask

  task automatic test_load_use();
    wr(4'd5, 16'h1357);
    bus.valid_i = 1'b1; bus.instr_i = 16'hB500; bus.next_pc_i = 16'd10;
    step();
    exp_out = {1'b1, 16'd10, 4'hB, 4'h5, 16'h0000, 16'h0000};
    total++;
    if (outs() !== exp_out) begin
      bad++;
      $display("FAIL load_accept: got=%h want=%h", outs(), exp_out);
    end
    bus.instr_i = 16'h1650; bus.next_pc_i = 16'd11;
    #1;
    total++;
    if (bus.stall_o !== 1'b1) begin
      bad++;
      $display("FAIL hazard_stall: got=%b want=1", bus.stall_o);
    end
    step();
    exp_bub++;
    total++;
    if (outs() !== 57'd0) begin
      bad++;
      $display("FAIL hazard_bubble: got=%h want=0", outs());
    end
    total++;
    if (bus.stall_o !== 1'b0) begin
      bad++;
      $display("FAIL hazard_selfclear: got=%b want=0", bus.stall_o);
    end
    step();
    exp_out = {1'b1, 16'd11, 4'h1, 4'h6, 16'h1357, 16'h0000};
    total++;
    if (outs() !== exp_out) begin
      bad++;
      $display("FAIL hazard_retry: got=%h want=%h", outs(), exp_out);
    end
    bus.instr_i = 16'hB000; bus.next_pc_i = 16'd12;
    step();
    bus.instr_i = 16'h1000; bus.next_pc_i = 16'd13;
    #1;
    total++;
    if (bus.stall_o !== 1'b0) begin
      bad++;
      $display("FAIL load_r0_nohazard: got=%b want=0", bus.stall_o);
    end
    bus.instr_i = 16'hB500; bus.next_pc_i = 16'd14;
    step();
    bus.valid_i = 1'b0; bus.instr_i = 16'h1650; bus.next_pc_i = 16'd15;
    #1;
    total++;
    if (bus.stall_o !== 1'b0) begin
      bad++;
      $display("FAIL invalid_nohazard: got=%b want=0", bus.stall_o);
    end
    step();
    exp_out = {1'b0, 16'd15, 4'h1, 4'h6, 16'h1357, 16'h0000};
    total++;
    if (outs() !== exp_out) begin
      bad++;
      $display("FAIL invalid_fields: got=%h want=%h", outs(), exp_out);
    end
`ifdef IDEX_PERF_CNT_EN
    total++;
    if (bus.bubble_cnt_o !== 32'(exp_bub)) begin
      bad++;
      $display("FAIL load_use_cnt: got=%0d want=%0d", bus.bubble_cnt_o, exp_bub);
    end
`endif
  endtask

  task automatic test_stall();
    logic [15:0] seq [3];
    seq[0] = 16'h3123; seq[1] = 16'hB456; seq[2] = 16'h7FFF;
    bus.valid_i = 1'b1; bus.instr_i = 16'h2A9A; bus.next_pc_i = 16'd42;
    step();
    exp_out = {1'b1, 16'd42, 4'h2, 4'hA, 16'h00AA, 16'h0055};
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.instr_i   = seq[i];
      bus.next_pc_i = 16'(100 + i);
      bus.we3_i     = (i == 0);
      bus.wa3_i     = 4'd7;
      bus.wd3_i     = 16'h7777;
      #1;
      total++;
      if (bus.stall_o !== 1'b1) begin
        bad++;
        $display("FAIL stall_o_%0d: got=%b want=1", i, bus.stall_o);
      end
      step();
      total++;
      if (outs() !== exp_out) begin
        bad++;
        $display("FAIL stall_hold_%0d: got=%h want=%h", i, outs(), exp_out);
      end
    end
    bus.stall_i = 1'b0; bus.we3_i = 1'b0;
    bus.instr_i = 16'h1070; bus.next_pc_i = 16'd50;
    step();
    exp_out = {1'b1, 16'd50, 4'h1, 4'h0, 16'h7777, 16'h0000};
    total++;
    if (outs() !== exp_out) begin
      bad++;
      $display("FAIL write_during_stall: got=%h want=%h", outs(), exp_out);
    end
`ifdef IDEX_PERF_CNT_EN
    total++;
    if (bus.bubble_cnt_o !== 32'(exp_bub)) begin
      bad++;
      $display("FAIL stall_cnt: got=%0d want=%0d", bus.bubble_cnt_o, exp_bub);
    end
`endif
  endtask

  task automatic test_flush();
    bus.flush_i = 1'b1; bus.stall_i = 1'b1;
    bus.valid_i = 1'b1; bus.instr_i = 16'h2A9A; bus.next_pc_i = 16'd60;
    #1;
    total++;
    if (bus.stall_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_stall_o: got=%b want=1", bus.stall_o);
    end
    step();
    exp_bub++;
    total++;
    if (outs() !== 57'd0) begin
      bad++;
      $display("FAIL flush_over_stall: got=%h want=0", outs());
    end
    bus.flush_i = 1'b0; bus.stall_i = 1'b0;
    step();
    exp_out = {1'b1, 16'd60, 4'h2, 4'hA, 16'h00AA, 16'h0055};
    total++;
    if (outs() !== exp_out) begin
      bad++;
      $display("FAIL after_flush: got=%h want=%h", outs(), exp_out);
    end
    bus.instr_i = 16'hB500; bus.next_pc_i = 16'd61;
    step();
    bus.instr_i = 16'h1650; bus.next_pc_i = 16'd62; bus.flush_i = 1'b1;
    step();
    exp_bub++;
    total++;
    if (outs() !== 57'd0) begin
      bad++;
      $display("FAIL flush_over_hazard: got=%h want=0", outs());
    end
    bus.flush_i = 1'b0;
    step();
    exp_out = {1'b1, 16'd62, 4'h1, 4'h6, 16'h1357, 16'h0000};
    total++;
    if (outs() !== exp_out) begin
      bad++;
      $display("FAIL after_flush_hazard: got=%h want=%h", outs(), exp_out);
    end
`ifdef IDEX_PERF_CNT_EN
    total++;
    if (bus.bubble_cnt_o !== 32'(exp_bub)) begin
      bad++;
      $display("FAIL flush_cnt: got=%0d want=%0d", bus.bubble_cnt_o, exp_bub);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_decode();
    test_bypass();
    test_load_use();
    test_stall();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
